// File: rtl/fp_add_sched_pkg.sv
// Shared constants, tag type and round-robin helper for the FP adder scheduler.
package fp_add_sched_pkg;

    localparam int FP_W        = 32;
    // Index width covers every legal requester count (2..8).
    localparam int NUM_REQ_MAX = 8;
    localparam int IDX_W       = $clog2(NUM_REQ_MAX);

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } tag_t;

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx, input int num_req);
        return (int'(idx) == num_req - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/fp_add_rr_arbiter.sv
// Combinational round-robin arbiter: first eligible index at or after rr_ptr, wrapping.
module fp_add_rr_arbiter
    import fp_add_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [NUM_REQ-1:0] upper;
    logic [NUM_REQ-1:0] pick_src;

    always_comb begin
        // NOTE: every output gets a default before the loops so no path can infer a latch.
        upper     = '0;
        pick_src  = '0;
        grant     = '0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            upper[i] = eligible[i] && (IDX_W'(i) >= rr_ptr);
        end
        // Nothing eligible at or above the pointer means the search wraps to index 0.
        pick_src = (|upper) ? upper : eligible;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pick_src[i]) grant_idx = IDX_W'(i);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = (|eligible) && (grant_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one fixed-latency FP add/subtract unit among NUM_REQ requesters, with
// round-robin issue and a per-requester valid/ready response register.
module fp_add_scheduler
    import fp_add_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADD_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [FP_W*NUM_REQ-1:0] req_a,
    input  logic [FP_W*NUM_REQ-1:0] req_b,
    input  logic [NUM_REQ-1:0]      req_sub,
    output logic [FP_W-1:0]         add_src_a,
    output logic [FP_W-1:0]         add_src_b,
    output logic                    add_subtract,
    input  logic [FP_W-1:0]         add_dest,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [FP_W*NUM_REQ-1:0] resp_data,
    input  logic [NUM_REQ-1:0]      resp_ready
);

    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] busy_q, busy_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [FP_W-1:0]    resp_data_q [NUM_REQ];
    logic [FP_W-1:0]    resp_data_d [NUM_REQ];
    tag_t               tag_q [ADD_LAT];
    tag_t               tag_d [ADD_LAT];

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] capture;
    logic [IDX_W-1:0]   grant_idx;

    assign eligible = req_valid & ~busy_q;

    fp_add_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Nothing is handed to the adder while reset is held.
    assign req_ready = grant & {NUM_REQ{rst_n}};

    always_comb begin
        add_src_a    = '0;
        add_src_b    = '0;
        add_subtract = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                add_src_a    = req_a[FP_W*i +: FP_W];
                add_src_b    = req_b[FP_W*i +: FP_W];
                add_subtract = req_sub[i];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (|req_ready) rr_ptr_d = rr_next(grant_idx, NUM_REQ);

        tag_d[0].vld = |req_ready;
        tag_d[0].idx = grant_idx;
        for (int s = 1; s < ADD_LAT; s++) begin
            tag_d[s] = tag_q[s-1];
        end

        // The last tag stage lines up with the adder result for that operation.
        capture = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            capture[i] = tag_q[ADD_LAT-1].vld && (tag_q[ADD_LAT-1].idx == IDX_W'(i));
        end

        busy_d       = (busy_q | req_ready) & ~(resp_valid_q & resp_ready);
        resp_valid_d = (resp_valid_q & ~resp_ready) | capture;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_data_d[i] = capture[i] ? add_dest : resp_data_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            busy_q       <= '0;
            resp_valid_q <= '0;
            // NOTE: the tag pipe and response data are small register arrays, so they are
            // cleared too; that drops in-flight ops and makes resp_data defined after reset.
            for (int s = 0; s < ADD_LAT; s++) tag_q[s] <= '0;
            for (int i = 0; i < NUM_REQ; i++) resp_data_q[i] <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values whatever the statement order.
            rr_ptr_q     <= rr_ptr_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            for (int s = 0; s < ADD_LAT; s++) tag_q[s] <= tag_d[s];
            for (int i = 0; i < NUM_REQ; i++) resp_data_q[i] <= resp_data_d[i];
        end
    end

    assign resp_valid = resp_valid_q;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_resp
        assign resp_data[FP_W*g +: FP_W] = resp_data_q[g];
    end

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Scoreboard bench for fp_add_scheduler: an ADD_LAT=1 instance for arbitration and
// response tests, and an ADD_LAT=3 instance for ordering and latency.
module tb_fp_add_scheduler;

    localparam int N  = 4;
    localparam int NV = 9;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] r;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          due;
        int          idx;
    } exp_t;

    typedef struct {
        int cyc;
        int idx;
    } gnt_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [N-1:0]    req_valid, req_ready, req_sub, resp_valid, resp_ready;
    logic [32*N-1:0] req_a, req_b, resp_data;
    logic [31:0]     add_src_a, add_src_b, add_dest;
    logic            add_subtract;

    logic [N-1:0]    l3_req_valid, l3_req_ready, l3_req_sub, l3_resp_valid, l3_resp_ready;
    logic [32*N-1:0] l3_req_a, l3_req_b, l3_resp_data;
    logic [31:0]     l3_add_src_a, l3_add_src_b, l3_add_dest;
    logic            l3_add_subtract;

    fp_add_scheduler #(.NUM_REQ(N), .ADD_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .add_src_a(add_src_a), .add_src_b(add_src_b), .add_subtract(add_subtract),
        .add_dest(add_dest),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready)
    );

    fp_add_scheduler #(.NUM_REQ(N), .ADD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(l3_req_valid), .req_ready(l3_req_ready),
        .req_a(l3_req_a), .req_b(l3_req_b), .req_sub(l3_req_sub),
        .add_src_a(l3_add_src_a), .add_src_b(l3_add_src_b), .add_subtract(l3_add_subtract),
        .add_dest(l3_add_dest),
        .resp_valid(l3_resp_valid), .resp_data(l3_resp_data), .resp_ready(l3_resp_ready)
    );

    vec_t vec [NV];
    int   cur_vec  [N];
    int   ops_left [N];

    // Adder stand-in: looks up the hand-computed IEEE results of the directed vectors.
    function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b, input logic s);
        for (int k = 0; k < NV; k++) begin
            if (vec[k].a == a && vec[k].b == b && vec[k].sub == s) return vec[k].r;
        end
        return 32'hDEAD_BEEF;
    endfunction

    always @(posedge clk) add_dest <= fp_ref(add_src_a, add_src_b, add_subtract);

    logic [31:0] p3 [3];
    always @(posedge clk) begin
        p3[0] <= fp_ref(l3_add_src_a, l3_add_src_b, l3_add_subtract);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign l3_add_dest = p3[2];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    exp_t        sb [N][$];
    gnt_t        glog [$];
    logic [N-1:0] m_busy = '0;
    int          m_rr = 0;
    logic [N-1:0] rv_prev = '0;
    logic [31:0] held [N];
    exp_t        q3 [$];
    int          arr3 [$];
    logic [N-1:0] rv3_prev = '0;

    task automatic drive(input int i);
        req_valid[i]      = (ops_left[i] > 0);
        req_a[32*i +: 32] = vec[cur_vec[i]].a;
        req_b[32*i +: 32] = vec[cur_vec[i]].b;
        req_sub[i]        = vec[cur_vec[i]].sub;
    endtask

    // Requester agents: after each handshake move to the next vector or drop valid.
    initial begin : driver
        logic [N-1:0] hs;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    ops_left[i]--;
                    cur_vec[i] = (cur_vec[i] + 1) % NV;
                    drive(i);
                end
            end
        end
    end

    // Issue side: checks arbitration and operand mux, pushes expected responses.
    initial begin : issue_mon
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_rr   = 0;
                m_busy = '0;
                check("rst_req_ready", 32'(req_ready), 32'h0);
                check("rst_src_a", add_src_a, 32'h0);
                check("rst_src_b", add_src_b, 32'h0);
                check("rst_subtract", 32'(add_subtract), 32'h0);
            end else begin
                logic [N-1:0] elig, exp_g;
                logic [31:0]  ea, eb;
                logic         es;
                elig  = req_valid & ~m_busy;
                exp_g = '0;
                ea = '0; eb = '0; es = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (exp_g == '0 && elig[(m_rr + k) % N]) begin
                        exp_g[(m_rr + k) % N] = 1'b1;
                        ea = vec[cur_vec[(m_rr + k) % N]].a;
                        eb = vec[cur_vec[(m_rr + k) % N]].b;
                        es = vec[cur_vec[(m_rr + k) % N]].sub;
                    end
                end
                check("grant", 32'(req_ready), 32'(exp_g));
                check("src_a", add_src_a, ea);
                check("src_b", add_src_b, eb);
                check("subtract", 32'(add_subtract), 32'(es));
                for (int i = 0; i < N; i++) begin
                    if (req_ready[i]) begin
                        sb[i].push_back('{data: vec[cur_vec[i]].r, due: cyc + 2, idx: i});
                        glog.push_back('{cyc: cyc, idx: i});
                        m_busy[i] = 1'b1;
                        m_rr = (i == N - 1) ? 0 : i + 1;
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (resp_valid[i] && resp_ready[i]) m_busy[i] = 1'b0;
                end
            end
        end
    end

    // Response side: pops the scoreboard on each new result, checks holding while pending.
    initial begin : resp_mon
        exp_t        e;
        logic [31:0] d;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < N; i++) sb[i].delete();
                rv_prev = '0;
                check("rst_resp_valid", 32'(resp_valid), 32'h0);
            end else begin
                for (int i = 0; i < N; i++) begin
                    d = resp_data[32*i +: 32];
                    if (resp_valid[i] && !rv_prev[i]) begin
                        if (sb[i].size() == 0) begin
                            check("resp_unexpected", 32'(resp_valid[i]), 32'h0);
                        end else begin
                            e = sb[i].pop_front();
                            check("resp_data", d, e.data);
                            check("resp_latency", 32'(cyc), 32'(e.due));
                        end
                        held[i] = d;
                    end else if (resp_valid[i]) begin
                        check("resp_hold", d, held[i]);
                    end
                end
                rv_prev = resp_valid;
            end
        end
    end

    initial begin : l3_issue_mon
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q3.delete();
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (l3_req_valid[i] && l3_req_ready[i])
                        q3.push_back('{data: vec[4 + i].r, due: cyc + 4, idx: i});
                end
            end
        end
    end

    // ADD_LAT=3 results must come back in issue order, so one global queue is the reference.
    initial begin : l3_resp_mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rv3_prev = '0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (l3_resp_valid[i] && !rv3_prev[i]) begin
                        if (q3.size() == 0) begin
                            check("l3_resp_unexpected", 32'(l3_resp_valid[i]), 32'h0);
                        end else begin
                            e = q3.pop_front();
                            check("l3_resp_idx", 32'(i), 32'(e.idx));
                            check("l3_resp_data", l3_resp_data[32*i +: 32], e.data);
                            check("l3_resp_latency", 32'(cyc), 32'(e.due));
                        end
                        arr3.push_back(i);
                    end
                end
                rv3_prev = l3_resp_valid;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input int i, input int n);
        ops_left[i] = n;
        drive(i);
    endtask

    task automatic stop_all();
        for (int i = 0; i < N; i++) begin
            ops_left[i] = 0;
            drive(i);
        end
    endtask

    task automatic apply_reset();
        stop_all();
        l3_req_valid = '0;
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int t = 0; t < 80 && !done; t++) begin
            step();
            done = (req_valid == '0) && (resp_valid == '0) && (m_busy == '0);
            for (int i = 0; i < N; i++) if (sb[i].size() != 0) done = 1'b0;
        end
        check(name, 32'(done), 32'h1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        int g2, total, base, pc, gcyc;
        logic found;
        logic [N-1:0] h;

        vec[0] = '{32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000}; //  1.0 + 2.0  = 3.0
        vec[1] = '{32'h4000_0000, 32'h3F80_0000, 1'b1, 32'h3F80_0000}; //  2.0 - 1.0  = 1.0
        vec[2] = '{32'h3FC0_0000, 32'h3F80_0000, 1'b0, 32'h4020_0000}; //  1.5 + 1.0  = 2.5
        vec[3] = '{32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000}; //  3.0 - 1.0  = 2.0
        vec[4] = '{32'h4080_0000, 32'h3F80_0000, 1'b0, 32'h40A0_0000}; //  4.0 + 1.0  = 5.0
        vec[5] = '{32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hBF80_0000}; //  1.0 - 2.0  = -1.0
        vec[6] = '{32'h3F00_0000, 32'h3E80_0000, 1'b0, 32'h3F40_0000}; //  0.5 + 0.25 = 0.75
        vec[7] = '{32'h4120_0000, 32'hC000_0000, 1'b0, 32'h4100_0000}; // 10.0 + -2.0 = 8.0
        vec[8] = '{32'h4000_0000, 32'h4000_0000, 1'b0, 32'h4080_0000}; //  2.0 + 2.0  = 4.0

        for (int i = 0; i < N; i++) begin
            cur_vec[i]  = i;
            ops_left[i] = 0;
            drive(i);
        end
        resp_ready    = '1;
        l3_req_valid  = '0;
        l3_req_sub    = '0;
        l3_req_a      = '0;
        l3_req_b      = '0;
        l3_resp_ready = '1;

        // Requests presented during reset must not be granted.
        rst_n     = 1'b0;
        req_valid = '1;
        repeat (3) step();
        check("reset_req_ready", 32'(req_ready), 32'h0);
        check("reset_resp_data1", resp_data[63:32], 32'h0);
        req_valid = '0;
        rst_n     = 1'b1;
        step();

        // Reset with an op in flight: no response, pointer back at 0.
        issue(0, 1);
        step();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) begin
            step();
            check("midop_no_resp", 32'(resp_valid), 32'h0);
        end
        glog.delete();
        issue(0, 1);
        issue(1, 1);
        wait_idle("midop_idle");
        check("midop_grant_count", 32'(glog.size()), 32'd2);
        if (glog.size() >= 1) check("midop_rr_zero", 32'(glog[0].idx), 32'd0);

        // Single op on requester 1: 1.0 + 2.0.
        cur_vec[1] = 0;
        issue(1, 1);
        wait_idle("single_idle");
        check("single_data", resp_data[63:32], 32'h4040_0000);

        // All four continuously valid: strict rotation at one grant per cycle.
        apply_reset();
        glog.delete();
        for (int i = 0; i < N; i++) issue(i, 6);
        wait_idle("rotate_idle");
        check("rotate_grant_count", 32'(glog.size()), 32'd24);
        if (glog.size() >= 12) begin
            for (int k = 0; k < 12; k++) begin
                check("rotate_idx", 32'(glog[k].idx), 32'(k % 4));
                check("rotate_cycle", 32'(glog[k].cyc), 32'(glog[0].cyc + k));
            end
        end

        // Requester 2 withholds resp_ready: it is granted once, others keep issuing.
        resp_ready = 4'b1011;
        glog.delete();
        for (int i = 0; i < N; i++) issue(i, 20);
        repeat (12) step();
        g2    = 0;
        total = glog.size();
        foreach (glog[k]) if (glog[k].idx == 2) g2++;
        check("hold_req2_grants", 32'(g2), 32'd1);
        check("hold_others_issue", 32'(total >= 9), 32'h1);
        check("pulse_pending", 32'(resp_valid[2]), 32'h1);
        base = glog.size();
        resp_ready[2] = 1'b1;
        pc = cyc;
        step();
        resp_ready[2] = 1'b0;
        found = 1'b0;
        gcyc  = 0;
        for (int t = 0; t < 10 && !found; t++) begin
            step();
            for (int k = base; k < glog.size(); k++) begin
                if (!found && glog[k].idx == 2) begin
                    found = 1'b1;
                    gcyc  = glog[k].cyc;
                end
            end
        end
        check("pulse_regrant_found", 32'(found), 32'h1);
        check("pulse_regrant_after", 32'(gcyc >= pc + 1), 32'h1);
        stop_all();
        resp_ready = '1;
        wait_idle("hold_idle");

        // Pointer at 3 with requesters 0 and 3: grant 3 then 0, then nothing while both busy.
        resp_ready = 4'b0100;
        issue(2, 1);
        wait_idle("ptr3_setup_idle");
        resp_ready = 4'b0000;
        glog.delete();
        issue(0, 2);
        issue(3, 2);
        repeat (6) step();
        check("ptr3_grant_count", 32'(glog.size()), 32'd2);
        if (glog.size() >= 2) begin
            check("ptr3_first", 32'(glog[0].idx), 32'd3);
            check("ptr3_second", 32'(glog[1].idx), 32'd0);
            check("ptr3_back_to_back", 32'(glog[1].cyc), 32'(glog[0].cyc + 1));
        end
        check("allbusy_req_ready", 32'(req_ready), 32'h0);
        check("allbusy_src_a", add_src_a, 32'h0);
        check("allbusy_src_b", add_src_b, 32'h0);
        resp_ready = '1;
        wait_idle("ptr3_idle");

        // ADD_LAT=3 instance: four interleaved ops, in-order return to the right slices.
        for (int i = 0; i < N; i++) begin
            l3_req_a[32*i +: 32] = vec[4 + i].a;
            l3_req_b[32*i +: 32] = vec[4 + i].b;
            l3_req_sub[i]        = vec[4 + i].sub;
        end
        l3_req_valid = '1;
        for (int t = 0; t < 12 && l3_req_valid != '0; t++) begin
            @(negedge clk);
            h = l3_req_valid & l3_req_ready;
            @(posedge clk);
            #2;
            l3_req_valid = l3_req_valid & ~h;
        end
        for (int t = 0; t < 20 && !(arr3.size() == 4 && l3_resp_valid == '0); t++) step();
        check("l3_arrivals", 32'(arr3.size()), 32'd4);
        if (arr3.size() == 4) begin
            for (int k = 0; k < 4; k++) check("l3_order", 32'(arr3[k]), 32'(k));
        end
        check("l3_data3", l3_resp_data[127:96], 32'h4100_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
